seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Multi-cycle signed two's-complement divider. It is the inverse companion of the team's radix-2 Booth multiplier datapath and shares its start/ready handshake style. It computes quotient and remainder of a DW-bit dividend by a DW-bit divisor using one restoring shift-subtract step per clock. It sits beside the multiplier in the arithmetic unit and is fed by the same control FSM.

Parameters:
DW, 8, operand/result width in bits (two's complement); legal range 2..32

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
dividend  input  DW  signed dividend, captured when start is accepted
divisor  input  DW  signed divisor, captured when start is accepted
busy  output  1  high from the cycle after start acceptance until ready drops
ready  output  1  one-cycle pulse: quotient/remainder/div_zero valid
quotient  output  DW  signed quotient, truncated toward zero
remainder  output  DW  signed remainder, sign of dividend (or zero)
div_zero  output  1  set with ready when divisor was zero

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0: state=IDLE, busy=0, ready=0, quotient=0, remainder=0, div_zero=0, iteration counter=0, internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start=1 at a rising edge. At that edge:
  - latch |dividend| into the working Q register, |divisor| into M, and the sign bits of both operands;
  - clear the DW+1-bit partial remainder A;
  - load the counter with DW;
  - busy=1.
- CALC, one restoring step per edge:
  - shift {A,Q} left by 1;
  - compute T = A - {0,M} at DW+1 bits;
  - if T >= 0: A=T and Q[0]=1; otherwise keep the shifted A and set Q[0]=0;
  - decrement the counter.
  - After the step where the counter reaches 0, go to DONE.
- DONE (one cycle) -> IDLE:
  - at entry edge, register the outputs:
    - quotient = Q, negated if the latched signs differ;
    - remainder = A[DW-1:0], negated if the dividend was negative;
  - ready=1 for exactly this cycle; busy stays 1 during DONE;
  - on the next edge: ready=0, busy=0, state=IDLE.
- Latency: start sampled at edge 0 gives ready high in the cycle following edge DW+1. With DW=8 that is edge 9. Throughput is one division per DW+2 cycles; a new start is accepted on the edge that leaves DONE is NOT allowed, only in IDLE.
- Magnitude of the most-negative operand: take it as the unsigned DW-bit value 2^(DW-1). The working registers are wide enough that no overflow occurs internally.
- Divisor zero:
  - execute the normal DW-cycle flow with uniform latency;
  - outputs are forced to quotient = all ones, remainder = original dividend, div_zero=1;
  - div_zero is cleared on the next accepted start.
- Overflow case (most-negative / -1): quotient = most-negative value (wraps), remainder=0, div_zero=0.
- start while busy=1: ignored; no effect on the computation in flight.
- quotient/remainder/div_zero hold their last values until the next DONE entry or reset.
- Operand inputs may change freely after the acceptance edge.
- Reset asserted mid-operation: immediate return to the reset state and the operation is discarded. The first start after reset release behaves normally.

Test Plan:
- DW=8, dividend=100, divisor=7, start one cycle -> ready pulses exactly one cycle at edge 9, quotient=14 (0x0E), remainder=2, div_zero=0, busy high edges 1..9.
- dividend=-100 (0x9C), divisor=7 -> quotient=-14 (0xF2), remainder=-2 (0xFE); then dividend=100, divisor=-7 -> quotient=0xF2, remainder=0x02.
- dividend=5, divisor=0 -> ready at edge 9, div_zero=1, quotient=0xFF, remainder=0x05. A following 9/3 gives div_zero=0, quotient=3, remainder=0.
- dividend=-128 (0x80), divisor=-1 (0xFF) -> quotient=0x80, remainder=0, div_zero=0. Also dividend=-128, divisor=1 -> quotient=0x80, remainder=0.
- Start 50/5; pulse start with 9/3 at edge 4 -> second request ignored, result quotient=10, remainder=0. Outputs hold after ready until the next operation.
- Start 100/7, assert rst low at edge 5 -> all outputs 0 immediately, no ready pulse. After release, start 20/6 -> quotient=3, remainder=2 at edge 9 relative to the new start.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Multi-cycle signed divider: one restoring shift-subtract step per clock on operand magnitudes,
// with sign fix-up of quotient/remainder when the result is registered.
module seq_restoring_divider #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero
);

  localparam int unsigned CW = $clog2(DW + 1);
  localparam logic [CW-1:0] CntInit = CW'(DW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [DW:0]     a_q;
  logic [DW-1:0]   q_q;
  logic [DW-1:0]   m_q;
  logic [DW-1:0]   dvd_q;
  logic            sign_n_q;
  logic            sign_d_q;
  logic            zero_q;
  logic [CW-1:0]   cnt_q;

  logic [DW-1:0]   dividend_abs;
  logic [DW-1:0]   divisor_abs;
  logic [DW+1:0]   a_sh;
  logic [DW+1:0]   t;
  logic [DW:0]     a_nx;
  logic [DW-1:0]   q_nx;
  logic [DW-1:0]   quo_res;
  logic [DW-1:0]   rem_res;

  always_comb begin
    // Most-negative operand maps to 2^(DW-1), which is representable as an unsigned magnitude.
    dividend_abs = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
    divisor_abs  = divisor[DW-1]  ? (~divisor + 1'b1)  : divisor;

    // Extra top bit turns the trial subtraction's sign into a simple borrow check.
    a_sh = {a_q, q_q[DW-1]};
    t    = a_sh - {2'b00, m_q};
    if (!t[DW+1]) begin
      a_nx = t[DW:0];
      q_nx = {q_q[DW-2:0], 1'b1};
    end else begin
      a_nx = a_sh[DW:0];
      q_nx = {q_q[DW-2:0], 1'b0};
    end

    quo_res = (sign_n_q ^ sign_d_q) ? (~q_q + 1'b1) : q_q;
    rem_res = sign_n_q ? (~a_q[DW-1:0] + 1'b1) : a_q[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      dvd_q     <= '0;
      sign_n_q  <= 1'b0;
      sign_d_q  <= 1'b0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= '0;
            q_q      <= dividend_abs;
            m_q      <= divisor_abs;
            dvd_q    <= dividend;
            sign_n_q <= dividend[DW-1];
            sign_d_q <= divisor[DW-1];
            zero_q   <= (divisor == '0);
            cnt_q    <= CntInit;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          if (cnt_q != '0) begin
            a_q   <= a_nx;
            q_q   <= q_nx;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= StDone;
            ready   <= 1'b1;
            if (zero_q) begin
              quotient  <= '1;
              remainder <= dvd_q;
              div_zero  <= 1'b1;
            end else begin
              quotient  <= quo_res;
              remainder <= rem_res;
              div_zero  <= 1'b0;
            end
          end
        end
        StDone: begin
          ready   <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at DW=8.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  int total;
  int bad;

  seq_restoring_divider #(.DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .ready    (ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch a request; on return we sit #1 after the acceptance edge (edge 0).
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h3C;
  endtask

  // Returns the edge index (relative to edge 0) at which ready is seen, or -1 on timeout.
  task automatic wait_ready(input int first_edge, output int lat);
    lat = -1;
    for (int k = first_edge; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (quotient !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", quotient); end
    total++; if (remainder !== 8'h00) begin bad++; $display("FAIL reset_r got=%h want=00", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_zero); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int busy_err;
    int ready_err;
    busy_err = 0;
    ready_err = 0;
    launch(8'd100, 8'd7);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) busy_err++;
      if (ready !== (k == 9)) ready_err++;
    end
    total++; if (busy_err != 0) begin bad++; $display("FAIL basic_busy got=%0d_bad_edges want=0", busy_err); end
    total++; if (ready_err != 0) begin bad++; $display("FAIL basic_ready_timing got=%0d_bad_edges want=0", ready_err); end
    total++; if (quotient !== 8'h0E) begin bad++; $display("FAIL basic_q got=%h want=0e", quotient); end
    total++; if (remainder !== 8'h02) begin bad++; $display("FAIL basic_r got=%h want=02", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b want=0", div_zero); end
    @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_drop got=%b want=0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_drop got=%b want=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (quotient !== 8'h0E || remainder !== 8'h02) begin
      bad++; $display("FAIL basic_hold got=%h/%h want=0e/02", quotient, remainder);
    end
  endtask

  task automatic test_signs();
    logic [7:0] vec [3][4];
    int lat;
    // dividend, divisor, quotient, remainder
    vec[0] = '{8'h9C, 8'h07, 8'hF2, 8'hFE};
    vec[1] = '{8'h64, 8'hF9, 8'hF2, 8'h02};
    vec[2] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE};
    for (int i = 0; i < 3; i++) begin
      launch(vec[i][0], vec[i][1]);
      wait_ready(1, lat);
      total++; if (lat != 9) begin bad++; $display("FAIL signs%0d_lat got=%0d want=9", i, lat); end
      total++; if (quotient !== vec[i][2]) begin
        bad++; $display("FAIL signs%0d_q got=%h want=%h", i, quotient, vec[i][2]);
      end
      total++; if (remainder !== vec[i][3]) begin
        bad++; $display("FAIL signs%0d_r got=%h want=%h", i, remainder, vec[i][3]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    launch(8'd5, 8'd0);
    wait_ready(1, lat);
    total++; if (lat != 9) begin bad++; $display("FAIL dz_lat got=%0d want=9", lat); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_zero); end
    total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL dz_q got=%h want=ff", quotient); end
    total++; if (remainder !== 8'h05) begin bad++; $display("FAIL dz_r got=%h want=05", remainder); end
    launch(8'd9, 8'd3);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear_on_start got=%b want=0", div_zero); end
    wait_ready(1, lat);
    total++; if (lat != 9) begin bad++; $display("FAIL dz_next_lat got=%0d want=9", lat); end
    total++; if (quotient !== 8'h03 || remainder !== 8'h00 || div_zero !== 1'b0) begin
      bad++; $display("FAIL dz_next got=%h/%h/%b want=03/00/0", quotient, remainder, div_zero);
    end
  endtask

  task automatic test_overflow();
    int lat;
    launch(8'h80, 8'hFF);
    wait_ready(1, lat);
    total++; if (quotient !== 8'h80 || remainder !== 8'h00 || div_zero !== 1'b0) begin
      bad++; $display("FAIL ovf_m1 got=%h/%h/%b want=80/00/0", quotient, remainder, div_zero);
    end
    launch(8'h80, 8'h01);
    wait_ready(1, lat);
    total++; if (quotient !== 8'h80 || remainder !== 8'h00) begin
      bad++; $display("FAIL ovf_p1 got=%h/%h want=80/00", quotient, remainder);
    end
  endtask

  task automatic test_busy_start();
    int lat;
    launch(8'd50, 8'd5);
    repeat (3) @(posedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_ready(5, lat);
    total++; if (lat != 9) begin bad++; $display("FAIL busy_start_lat got=%0d want=9", lat); end
    total++; if (quotient !== 8'd10 || remainder !== 8'd0) begin
      bad++; $display("FAIL busy_start_res got=%h/%h want=0a/00", quotient, remainder);
    end
    repeat (4) @(posedge clk);
    #1;
    total++; if (quotient !== 8'd10 || ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_start_hold got=q%h rdy%b busy%b want=q0a rdy0 busy0",
                      quotient, ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    seen = 0;
    launch(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || ready !== 1'b0 || quotient !== 8'h00 || remainder !== 8'h00
                 || div_zero !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=b%b r%b q%h r%h dz%b want=all0",
                      busy, ready, quotient, remainder, div_zero);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_ready got=%0d want=0", seen); end
    @(negedge clk);
    rst = 1'b1;
    launch(8'd20, 8'd6);
    wait_ready(1, lat);
    total++; if (lat != 9) begin bad++; $display("FAIL rst_after_lat got=%0d want=9", lat); end
    total++; if (quotient !== 8'd3 || remainder !== 8'd2) begin
      bad++; $display("FAIL rst_after_res got=%h/%h want=03/02", quotient, remainder);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
